// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor -- passive checker on the intersection controller outputs.
// Watches both light codes, the walk indication and emergency. It latches sticky
// fault flags and a first-fault code, and counts completed green-yellow-red phases
// per direction. It has no outputs back to the controller.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   light_NS/EW[2:0]  RED=100, YELLOW=010, GREEN=001
//   pedestrian_signal walk indication
//   emergency         emergency request seen by the controller
//   clr               clears flags, first-fault code and phase counters
//   fault_flags[6:0]  sticky flags, bit i-1 <-> fault code i
//   fault             OR of fault_flags
//   first_fault[2:0]  first fault code since reset/clr, 0 = none
//   ns/ew_cycles[7:0] completed phases, saturating at 255
//   irq               one-cycle pulse when any flag rises; build with
//                     MONITOR_IRQ_EN defined, otherwise tied low
//
// Fault codes: 1 ILLEGAL, 2 CONFLICT, 3 PED_CONFLICT, 4 SEQ, 5 YELLOW_SHORT,
//              6 GREEN_LONG, 7 EMERG.

// Per-direction checker: encoding, step legality, yellow/green dwell.
module tlm_dir #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 16,
  parameter int DWELL_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       nonred,
  output logic       illegal,
  output logic       seq_err,
  output logic       yel_short,
  output logic       green_long,
  output logic       phase_done
);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  localparam logic [DWELL_W-1:0] DW_MAX = '1;

  logic [2:0]         prev;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic               cur_ok, prev_ok, changed, ok_step;

  always_comb begin
    cur_ok     = (light == RED) || (light == YEL) || (light == GRN);
    prev_ok    = (prev == RED) || (prev == YEL) || (prev == GRN);
    changed    = (light != prev);
    dwell_nxt  = changed ? DWELL_W'(1)
               : (dwell == DW_MAX) ? dwell : dwell + DWELL_W'(1);
    ok_step    = (prev == RED && light == GRN) || (prev == GRN && light == YEL) ||
                 (prev == YEL && light == RED);
    nonred     = (light != RED);
    illegal    = !cur_ok;
    seq_err    = cur_ok && prev_ok && changed && !ok_step;
    phase_done = (prev == YEL) && (light == RED);
    // dwell still holds the yellow run length on the Y->R sample
    yel_short  = phase_done && (int'(dwell) < MIN_YELLOW);
    // fire on the sample that first takes the green run past MAX_GREEN; a
    // counter saturated exactly there must not refire
    green_long = (light == GRN) && (int'(dwell_nxt) == MAX_GREEN + 1) &&
                 !((prev == GRN) && (int'(dwell) == MAX_GREEN + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= RED;
      dwell <= DWELL_W'(1);
    end else begin
      prev  <= light;
      dwell <= dwell_nxt;
    end
  end
endmodule

module traffic_light_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 16,
  parameter int EMERG_LAT  = 20,
  parameter int DWELL_W    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_NS,
  input  logic [2:0] light_EW,
  input  logic       pedestrian_signal,
  input  logic       emergency,
  input  logic       clr,
  output logic [6:0] fault_flags,
  output logic       fault,
  output logic [2:0] first_fault,
  output logic [7:0] ns_cycles,
  output logic [7:0] ew_cycles,
  output logic       irq
);
  localparam int NUM_DIR = 2;           // index 0 = NS, 1 = EW
  localparam int EC_W    = $clog2(EMERG_LAT + 2);
  localparam logic [EC_W-1:0] EMG_TRIP = EC_W'(EMERG_LAT + 1);

  logic [NUM_DIR-1:0][2:0] lights;
  logic [NUM_DIR-1:0]      nonred, illegal, seq_err, yel_short, green_long, phase_done;
  logic [NUM_DIR-1:0][7:0] cyc, cyc_nxt;
  logic [EC_W-1:0]         emg_cnt, emg_nxt;
  logic                    emg_hit;
  logic [6:0]              new_f, flags_nxt;
  logic [2:0]              code, ff_base, ff_nxt;

  assign lights = {light_EW, light_NS};

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    tlm_dir #(.MIN_YELLOW(MIN_YELLOW), .MAX_GREEN(MAX_GREEN), .DWELL_W(DWELL_W)) u_dir (
      .clk        (clk),
      .rst        (rst),
      .light      (lights[d]),
      .nonred     (nonred[d]),
      .illegal    (illegal[d]),
      .seq_err    (seq_err[d]),
      .yel_short  (yel_short[d]),
      .green_long (green_long[d]),
      .phase_done (phase_done[d])
    );
  end

  always_comb begin
    // counter saturates at the trip value so the flag fires once per episode
    emg_nxt = '0;
    if (emergency && |nonred)
      emg_nxt = (emg_cnt == EMG_TRIP) ? emg_cnt : emg_cnt + EC_W'(1);
    emg_hit = (emg_nxt == EMG_TRIP) && (emg_cnt != EMG_TRIP);

    new_f = {emg_hit, |green_long, |yel_short, |seq_err,
             pedestrian_signal && |nonred, &nonred, |illegal};

    // clr acts first, then this sample's faults accumulate on top
    flags_nxt = (clr ? 7'd0 : fault_flags) | new_f;

    code = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (new_f[i]) code = 3'(i + 1);
    ff_base = clr ? 3'd0 : first_fault;
    ff_nxt  = (ff_base == 3'd0) ? code : ff_base;

    for (int d = 0; d < NUM_DIR; d++) begin
      cyc_nxt[d] = clr ? 8'd0 : cyc[d];
      if (phase_done[d] && cyc_nxt[d] != 8'hFF) cyc_nxt[d] = cyc_nxt[d] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      emg_cnt     <= '0;
      fault_flags <= '0;
      first_fault <= '0;
      cyc         <= '0;
    end else begin
      emg_cnt     <= emg_nxt;
      fault_flags <= flags_nxt;
      first_fault <= ff_nxt;
      cyc         <= cyc_nxt;
    end
  end

  assign fault     = |fault_flags;
  assign ns_cycles = cyc[0];
  assign ew_cycles = cyc[1];

`ifdef MONITOR_IRQ_EN
  // pulse only on a 0->1 transition of the visible flag register
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(flags_nxt & ~fault_flags);
  end
`else
  assign irq = 1'b0;
`endif
endmodule
